dsp_div_signed_seq: RTL and testbench
=====================================

Name: dsp_div_signed_seq

Overview:
- Iterative signed divider, the inverse of the registered signed DSP multiplier.
- Takes a product-width dividend and a multiplier-B-width divisor, and returns the truncated quotient and remainder after a fixed latency.
- Used to recover a multiplicand from a product and to check multiplier results in soft logic.
- Restoring algorithm, one quotient bit per clock, start/busy/done handshake.

Parameters:
- DIVIDEND_W, 38, width of signed dividend N and signed quotient Q.
- DIVISOR_W, 18, width of signed divisor D and signed remainder R.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled at a rising edge only while busy=0.
- N  input  DIVIDEND_W  signed dividend, captured when start is accepted.
- D  input  DIVISOR_W  signed divisor, captured when start is accepted.
- Q  output  DIVIDEND_W  signed quotient, registered.
- R  output  DIVISOR_W  signed remainder, registered.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; Q/R/flags valid from this cycle on.
- dbz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  quotient overflow flag for the last result.

Behaviour:
- Reset (reset=0 at a rising edge):
  - Q, R, busy, done, dbz, ovf all go to 0; state goes to IDLE.
  - This applies in any state. An in-flight operation is aborted and its result discarded.
  - start is ignored while reset=0.
- States: IDLE -> LOAD -> ITER -> FIX -> IDLE.
- IDLE:
  - busy=0.
  - start=1 at an edge: capture N and D, go to LOAD, busy=1.
- LOAD (1 cycle):
  - Form unsigned magnitudes |N| (DIVIDEND_W bits; the most-negative value maps correctly) and |D| (DIVISOR_W bits).
  - Register the sign bits; clear partial remainder; load iteration counter with DIVIDEND_W-1.
- ITER (DIVIDEND_W cycles):
  - Each cycle shift the next |N| bit (MSB first) into the partial remainder (DIVISOR_W+1 bits).
  - Trial-subtract |D|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Counter decrements; leave ITER after the count-0 cycle.
- FIX (1 cycle):
  - Q = quotient magnitude, negated if sign(N)^sign(D).
  - R = remainder magnitude, negated if sign(N).
  - Truncation toward zero, identical to Verilog signed / and %.
  - Register Q/R/dbz/ovf, pulse done=1, set busy=0, return to IDLE.
- Latency:
  - start sampled at edge t0; done is high in the cycle after edge t0+DIVIDEND_W+2 (default: 40 cycles).
  - Latency is fixed for all operands, including error cases.
- Back-to-back: busy is already 0 in the done cycle, so start may be accepted at the edge that ends the done cycle.
- start while busy=1 is ignored, with no effect on the in-flight operation.
- Q/R/dbz/ovf hold their values until the next done or reset. done is high for exactly one cycle.
- Divide by zero (D=0): dbz=1, Q=all ones (-1), R=0, ovf=0.
- Overflow (N=-2^(DIVIDEND_W-1), D=-1): ovf=1, Q=-2^(DIVIDEND_W-1) (wraps), R=0, dbz=0.
- In all other cases dbz=0 and ovf=0.
- Invariant: |R| < |D|, so R always fits in DIVISOR_W bits.

Test Plan:
- Hold reset=0 for 2 edges with start=1, N=100, D=7:
  - Q=0, R=0, busy=0, done=0, dbz=0, ovf=0.
  - No operation starts after release until a new start arrives.
- N=100, D=7, start pulse at t0:
  - busy=1 for 40 cycles; done pulse after edge t0+40.
  - Q=14, R=2, flags 0.
- Sign combinations, each checked against Verilog / and %:
  - -100/7 -> Q=-14, R=-2.
  - 100/-7 -> Q=-14, R=2.
  - -100/-7 -> Q=14, R=-2.
- Multiplier inverse: N=-68718952448 (=-524288*131071), D=131071 -> Q=-524288, R=0.
- Error cases:
  - N=5, D=0 -> dbz=1, Q=-1, R=0.
  - N=-2^37, D=-1 -> ovf=1, Q=-2^37, R=0.
- Control corner cases:
  - start with N=9, D=2 while busy (cycle 10 of an op 100/7) -> ignored; result stays 14/2.
  - reset=0 at cycle 20 of an op -> busy=0, no done.
  - Back-to-back start in the done cycle -> second result correct 40 cycles later.
  - Then 1000 random N/D pairs compared against a reference model: 0 mismatches.

Source files
------------

// File: rtl/dsp_div_signed_seq.sv
// dsp_div_signed_seq: restoring signed divider, one quotient bit per clock, truncating like Verilog / and %
module dsp_div_signed_seq #(
  parameter int DIVIDEND_W = 38,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] N,
  input  logic [DIVISOR_W-1:0]  D,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz,
  output logic                  ovf
);
  localparam int CW = $clog2(DIVIDEND_W);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;
  state_t state, state_n;
  logic [DIVIDEND_W-1:0] n_r, nq;
  logic [DIVISOR_W-1:0] d_r, dmag, rem;
  logic [DIVISOR_W:0] shifted;
  logic [CW-1:0] cnt;
  logic sn, sd, dbz_r, ovf_r, ok;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = ITER;
      ITER: state_n = (cnt == '0) ? FIX : ITER;
      FIX:  state_n = IDLE;
    endcase
  end
  // nq holds the dividend magnitude and fills with quotient bits as it shifts out
  assign shifted = {rem, nq[DIVIDEND_W-1]};
  assign ok = shifted >= {1'b0, dmag};
  always_ff @(posedge clk)
    if (!reset) begin
      Q    <= '0;
      R    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      done <= state == FIX;
      case (state)
        IDLE: if (start) begin
          n_r <= N;
          d_r <= D;
        end
        LOAD: begin
          nq    <= n_r[DIVIDEND_W-1] ? -n_r : n_r;
          dmag  <= d_r[DIVISOR_W-1] ? -d_r : d_r;
          sn    <= n_r[DIVIDEND_W-1];
          sd    <= d_r[DIVISOR_W-1];
          rem   <= '0;
          cnt   <= CW'(DIVIDEND_W - 1);
          dbz_r <= d_r == '0;
          ovf_r <= (n_r == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (&d_r);
        end
        ITER: begin
          rem <= DIVISOR_W'(ok ? shifted - {1'b0, dmag} : shifted);
          nq  <= {nq[DIVIDEND_W-2:0], ok};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          Q   <= dbz_r ? '1 : (sn ^ sd) ? -nq : nq;
          R   <= dbz_r ? '0 : sn ? -rem : rem;
          dbz <= dbz_r;
          ovf <= ovf_r;
        end
      endcase
    end
endmodule

// File: tb/tb_dsp_div_signed_seq.sv
// tb_dsp_div_signed_seq: directed and random checks of the signed divider against a longint arithmetic model
module tb_dsp_div_signed_seq;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [37:0] N = '0;
  logic [17:0] D = '0;
  logic [37:0] Q;
  logic [17:0] R;
  logic busy, done, dbz, ovf;
  int n_chk = 0, n_fail = 0;

  dsp_div_signed_seq dut (
    .clk(clk), .reset(reset), .start(start), .N(N), .D(D),
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input logic signed [37:0] n, input logic signed [17:0] d);
    longint a, b, q, r;
    logic edbz, eovf;
    a = longint'(n);
    b = longint'(d);
    edbz = b == 0;
    eovf = (a == -(longint'(1) << 37)) && (b == -1);
    q = edbz ? -1 : a / b;
    r = edbz ? 0 : a % b;
    check("Q", 64'(Q), 64'(q[37:0]));
    check("R", 64'(R), 64'(r[17:0]));
    check("dbz", 64'(dbz), 64'(edbz));
    check("ovf", 64'(ovf), 64'(eovf));
  endtask

  task automatic launch(input logic [37:0] n, input logic [17:0] d);
    N = n;
    D = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int k, output int busy_cnt);
    k = 0;
    busy_cnt = 0;
    while (k < 100) begin
      @(negedge clk);
      if (done) break;
      busy_cnt += int'(busy);
      k++;
    end
    if (k >= 100) check("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic run(input logic signed [37:0] n, input logic signed [17:0] d);
    int k, b;
    launch(n, d);
    wait_done(k, b);
    check("latency", 64'(k), 64'(40));
    check("busy_cycles", 64'(b), 64'(40));
    check("busy_at_done", 64'(busy), 64'(0));
    expect_result(n, d);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    int k, b, t, u;
    bit seen;
    logic signed [37:0] rn;
    logic signed [17:0] rd;
    reset = 1'b0;
    start = 1'b1;
    N = 38'd100;
    D = 18'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_Q", 64'(Q), 64'(0));
    check("rst_R", 64'(R), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    reset = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));

    run(38'sd100, 18'sd7);
    check("hold_Q", 64'(Q), 64'(14));
    run(-38'sd100, 18'sd7);
    run(38'sd100, -18'sd7);
    run(-38'sd100, -18'sd7);
    run(-38'sd68718952448, 18'sd131071);
    run(38'sd5, 18'sd0);
    run({1'b1, 37'd0}, -18'sd1);

    launch(38'sd100, 18'sd7);
    repeat (9) @(negedge clk);
    N = 38'd9;
    D = 18'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, b);
    expect_result(38'sd100, 18'sd7);
    @(negedge clk);

    launch(38'sd100, 18'sd7);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_Q", 64'(Q), 64'(0));
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", 64'(seen), 64'(0));

    launch(38'sd1234, -18'sd5);
    wait_done(k, b);
    expect_result(38'sd1234, -18'sd5);
    launch(-38'sd777, 18'sd13);
    wait_done(k, b);
    check("b2b_latency", 64'(k), 64'(40));
    expect_result(-38'sd777, 18'sd13);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      t = $urandom_range(0, 2000);
      case ($urandom_range(0, 7))
        0: rn = 38'(t - 1000);
        1: rn = {1'b1, 37'd0};
        default: rn = 38'({$urandom(), $urandom()});
      endcase
      u = $urandom_range(1, 20);
      case ($urandom_range(0, 7))
        0: rd = '0;
        1: rd = -18'sd1;
        2: rd = 18'($urandom_range(0, 1) ? u : -u);
        default: rd = 18'($urandom());
      endcase
      run(rn, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
